// File: rtl/clock_mode_ctrl.sv
// Alarm clock mode sequencer: derives time/alarm counter enables from the
// 1 Hz tick and user buttons, and runs the alarm ring timer.
module clock_mode_ctrl #(
  parameter int unsigned RING_SECONDS = 60,
  parameter int unsigned RING_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       alarm_on,
  input  logic       sec_at_max,
  input  logic       min_at_max,
  input  logic       time_match,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       alm_min_en,
  output logic       alm_hour_en,
  output logic [2:0] mode,
  output logic       ring,
  output logic       blink
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_TIME_H = 3'd1,
    SET_TIME_M = 3'd2,
    SET_ALM_H  = 3'd3,
    SET_ALM_M  = 3'd4
  } state_t;

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);

  state_t            state;
  state_t            state_next;
  logic              match_q;
  logic [RING_W-1:0] ring_cnt;

  logic advance;
  logic inc_ok;
  logic ring_start;
  logic ring_stop;

  // While ringing, either button is swallowed as a dismiss.
  assign advance    = mode_btn & ~ring;
  assign inc_ok     = inc_btn & ~mode_btn & ~ring;
  assign ring_start = (state == RUN) & alarm_on & time_match & ~match_q;
  assign ring_stop  = ring & ((tick & (ring_cnt == RING_LAST)) |
                              mode_btn | inc_btn | ~alarm_on);
  assign mode       = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      match_q <= 1'b0;
    end else begin
      state   <= state_next;
      match_q <= time_match;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:        if (advance) state_next = SET_TIME_H;
      SET_TIME_H: if (advance) state_next = SET_TIME_M;
      SET_TIME_M: if (advance) state_next = SET_ALM_H;
      SET_ALM_H:  if (advance) state_next = SET_ALM_M;
      SET_ALM_M:  if (advance) state_next = RUN;
      default:    state_next = RUN;
    endcase
  end

  always_comb begin
    sec_en      = 1'b0;
    min_en      = 1'b0;
    hour_en     = 1'b0;
    alm_min_en  = 1'b0;
    alm_hour_en = 1'b0;
    case (state)
      RUN, SET_ALM_H, SET_ALM_M: begin
        sec_en  = tick;
        min_en  = tick & sec_at_max;
        hour_en = tick & sec_at_max & min_at_max;
        if (state == SET_ALM_H) alm_hour_en = inc_ok;
        if (state == SET_ALM_M) alm_min_en  = inc_ok;
      end
      SET_TIME_H: hour_en = inc_ok;
      SET_TIME_M: min_en  = inc_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (ring) begin
      if (ring_stop) begin
        ring     <= 1'b0;
        ring_cnt <= '0;
      end else if (tick) begin
        ring_cnt <= ring_cnt + 1'b1;
      end
    end else if (ring_start) begin
      ring     <= 1'b1;
      ring_cnt <= '0;
    end
  end

  // Entering a set state forces the visible phase; thereafter each tick flips it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink <= 1'b0;
    end else if (state_next == RUN) begin
      blink <= 1'b0;
    end else if (state_next != state) begin
      blink <= 1'b1;
    end else if (tick) begin
      blink <= ~blink;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_clock_mode_ctrl;

  logic clk = 1'b0;
  logic rst, tick, mode_btn, inc_btn, alarm_on, sec_at_max, min_at_max, time_match;
  logic sec_en, min_en, hour_en, alm_min_en, alm_hour_en, ring, blink;
  logic [2:0] mode;

  clock_mode_ctrl #(.RING_SECONDS(60), .RING_W(6)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .alarm_on(alarm_on), .sec_at_max(sec_at_max), .min_at_max(min_at_max),
    .time_match(time_match), .sec_en(sec_en), .min_en(min_en), .hour_en(hour_en),
    .alm_min_en(alm_min_en), .alm_hour_en(alm_hour_en), .mode(mode), .ring(ring),
    .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] val;
    logic [9:0] mask;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  localparam logic [9:0] ALL     = 10'h3FF;
  localparam logic [9:0] NOBLINK = 10'h3F7;

  // {sec, min, hour, alm_min, alm_hour, ring, blink, mode}
  function automatic logic [9:0] pk(bit s, bit m, bit h, bit am, bit ah,
                                    bit r, bit b, logic [2:0] md);
    return {s, m, h, am, ah, r, b, md};
  endfunction

  task automatic expect_out(input string name, input logic [9:0] val,
                            input logic [9:0] mask);
    exp_t e;
    e.name = name; e.val = val; e.mask = mask;
    q.push_back(e);
  endtask

  task automatic cyc(input bit t, input bit m, input bit i);
    @(posedge clk); #1;
    tick = t; mode_btn = m; inc_btn = i;
  endtask

  always @(negedge clk) begin
    logic [9:0] act;
    act = pk(sec_en, min_en, hour_en, alm_min_en, alm_hour_en, ring, blink, mode);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compared++;
      if (((act ^ e.val) & e.mask) != 10'd0) begin
        mismatched++;
        $display("FAIL %s: got %b want %b (mask %b)", e.name, act, e.val, e.mask);
      end
    end
  end

  int s_mod, m_mod;

  initial begin
    rst = 1'b1; tick = 0; mode_btn = 0; inc_btn = 0; alarm_on = 0;
    sec_at_max = 0; min_at_max = 0; time_match = 0;
    @(posedge clk); #1;
    expect_out("reset", pk(0,0,0,0,0,0,0,3'd0), ALL);
    @(posedge clk); #1; rst = 1'b0;

    // 120 ticks in RUN against seconds/minutes counter models
    s_mod = 0; m_mod = 0;
    for (int k = 0; k < 120; k++) begin
      cyc(1, 0, 0);
      sec_at_max = (s_mod == 59); min_at_max = (m_mod == 59);
      expect_out("run_tick", pk(1, s_mod == 59, 0, 0, 0, 0, 0, 3'd0), ALL);
      if (s_mod == 59) begin s_mod = 0; m_mod++; end else s_mod++;
      cyc(0, 0, 0);
      sec_at_max = (s_mod == 59); min_at_max = (m_mod == 59);
      expect_out("run_idle", pk(0,0,0,0,0,0,0,3'd0), ALL);
    end
    if (m_mod != 2) begin
      mismatched++;
      $display("FAIL min_model: got %0d want 2", m_mod);
    end
    compared++;

    // Editing walk; counters report max so a leaked tick would carry.
    sec_at_max = 1; min_at_max = 1;
    cyc(0, 0, 1); expect_out("run_inc_ignored", pk(0,0,0,0,0,0,0,3'd0), ALL);
    cyc(0, 1, 0); expect_out("run_mode",  pk(0,0,0,0,0,0,0,3'd0), ALL);
    cyc(0, 0, 1); expect_out("th_inc1",   pk(0,0,1,0,0,0,1,3'd1), ALL);
    cyc(1, 0, 0); expect_out("th_tick",   pk(0,0,0,0,0,0,1,3'd1), ALL);
    cyc(0, 0, 1); expect_out("th_inc2",   pk(0,0,1,0,0,0,0,3'd1), ALL);
    cyc(1, 0, 1); expect_out("th_inc3",   pk(0,0,1,0,0,0,0,3'd1), ALL);
    cyc(0, 1, 0); expect_out("th_mode",   pk(0,0,0,0,0,0,1,3'd1), ALL);
    cyc(0, 0, 1); expect_out("tm_inc",    pk(0,1,0,0,0,0,1,3'd2), ALL);
    cyc(0, 1, 1); expect_out("tm_both",   pk(0,0,0,0,0,0,1,3'd2), ALL);
    cyc(1, 0, 0); expect_out("ah_tick",   pk(1,1,1,0,0,0,1,3'd3), ALL);
    cyc(0, 0, 1); expect_out("ah_inc",    pk(0,0,0,0,1,0,0,3'd3), ALL);
    cyc(0, 1, 0); expect_out("ah_mode",   pk(0,0,0,0,0,0,0,3'd3), ALL);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1); expect_out("am_inc", pk(0,0,0,1,0,0,1,3'd4), ALL);
    end
    cyc(0, 1, 0); expect_out("am_mode",   pk(0,0,0,0,0,0,1,3'd4), ALL);
    cyc(0, 0, 0); expect_out("back_run",  pk(0,0,0,0,0,0,0,3'd0), ALL);
    sec_at_max = 0; min_at_max = 0;

    // Full-length ring
    alarm_on = 1;
    cyc(0, 0, 0); time_match = 1; expect_out("match_rise", pk(0,0,0,0,0,0,0,3'd0), ALL);
    cyc(0, 0, 0); expect_out("ring_on", pk(0,0,0,0,0,1,0,3'd0), ALL);
    for (int k = 1; k <= 60; k++) begin
      cyc(1, 0, 0); expect_out("ring_tick", pk(1,0,0,0,0,1,0,3'd0), ALL);
      cyc(0, 0, 0); expect_out("ring_len", pk(0,0,0,0,0, k < 60, 0, 3'd0), ALL);
    end
    cyc(0, 0, 0); expect_out("no_rering", pk(0,0,0,0,0,0,0,3'd0), ALL);

    // Dismiss with inc_btn after 5 ticks
    cyc(0, 0, 0); time_match = 0; expect_out("match_low", pk(0,0,0,0,0,0,0,3'd0), ALL);
    cyc(0, 0, 0); time_match = 1; expect_out("match_rise2", pk(0,0,0,0,0,0,0,3'd0), ALL);
    cyc(0, 0, 0); expect_out("ring_on2", pk(0,0,0,0,0,1,0,3'd0), ALL);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0); expect_out("ring2_tick", pk(1,0,0,0,0,1,0,3'd0), ALL);
    end
    cyc(0, 0, 1); expect_out("dismiss_inc", pk(0,0,0,0,0,1,0,3'd0), ALL);
    cyc(0, 0, 0); expect_out("dismissed",   pk(0,0,0,0,0,0,0,3'd0), ALL);

    // Dismiss with mode_btn: no mode change
    cyc(0, 0, 0); time_match = 0;
    cyc(0, 0, 0); time_match = 1;
    cyc(0, 0, 0); expect_out("ring_on3", pk(0,0,0,0,0,1,0,3'd0), ALL);
    cyc(0, 1, 0); expect_out("dismiss_mode", pk(0,0,0,0,0,1,0,3'd0), ALL);
    cyc(0, 0, 0); expect_out("mode_kept", pk(0,0,0,0,0,0,0,3'd0), ALL);

    // alarm_on dropping stops the ring
    cyc(0, 0, 0); time_match = 0;
    cyc(0, 0, 0); time_match = 1;
    cyc(1, 0, 0); expect_out("ring_on4", pk(1,0,0,0,0,1,0,3'd0), ALL);
    cyc(0, 0, 0); alarm_on = 0; expect_out("alarm_off", pk(0,0,0,0,0,1,0,3'd0), ALL);
    cyc(0, 0, 0); alarm_on = 1; expect_out("ring_off4", pk(0,0,0,0,0,0,0,3'd0), ALL);

    // Match rising during a set state must not ring later
    cyc(0, 0, 0); time_match = 0;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0); time_match = 1; expect_out("set_match", pk(0,0,0,0,0,0,0,3'd3), NOBLINK);
    cyc(0, 0, 0); expect_out("set_noring", pk(0,0,0,0,0,0,0,3'd3), NOBLINK);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0); expect_out("run_noring", pk(0,0,0,0,0,0,0,3'd0), ALL);
    end

    // Async reset mid-ring at counter 30
    cyc(0, 0, 0); time_match = 0;
    cyc(0, 0, 0); time_match = 1;
    for (int k = 0; k < 30; k++) cyc(1, 0, 0);
    cyc(0, 0, 0); expect_out("pre_rst_ring", pk(0,0,0,0,0,1,0,3'd0), ALL);
    @(posedge clk); #1; rst = 1'b1;
    expect_out("rst_mid_ring", pk(0,0,0,0,0,0,0,3'd0), ALL);
    @(posedge clk); #1; rst = 1'b0;

    // Async reset mid-edit
    time_match = 0;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0); expect_out("pre_rst_edit", pk(0,0,0,0,0,0,1,3'd2), ALL);
    @(posedge clk); #1; rst = 1'b1;
    expect_out("rst_mid_edit", pk(0,0,0,0,0,0,0,3'd0), ALL);
    @(posedge clk); #1; rst = 1'b0;

    @(negedge clk); #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
